// File: rtl/dm_asid_bank.sv
// ASID-partitioned data memory: byte-enabled synchronous writes, registered reads,
// alignment/range fault reporting and a per-partition clear engine.
module dm_asid_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ASID_W = 8,
    parameter int PARTS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ASID_W-1:0]    ASID,
    input  logic                 RReq,
    input  logic [ADDR_W-1:0]    RAddr,
    output logic                 RReady,
    output logic                 RValid,
    output logic [DATA_W-1:0]    RData,
    output logic                 RErr,
    input  logic                 WEn,
    input  logic [ADDR_W-1:0]    WAddr,
    input  logic [DATA_W/8-1:0]  WBe,
    input  logic [DATA_W-1:0]    WData,
    output logic                 WReady,
    output logic                 WErr,
    input  logic                 ClrReq,
    input  logic [ASID_W-1:0]    ClrAsid,
    output logic                 Busy,
    output logic                 ClrDone,
    output logic [1:0]           dbg_state
);
    localparam int BE_W   = DATA_W / 8;
    localparam int PW     = DEPTH / PARTS;
    localparam int PART_W = $clog2(PARTS);
    localparam int BO_W   = $clog2(BE_W);
    localparam int OFF_W  = $clog2(PW);
    localparam int IDX_W  = PART_W + OFF_W;
    localparam int HI_LSB = BO_W + OFF_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Handshake: a request is taken on a rising edge where its Req/En and the
    // matching Ready are both 1; while Ready=0 the requester must hold the request.

    state_t              state, state_nxt;
    logic [PART_W-1:0]   clr_part, clr_part_nxt;
    logic [OFF_W-1:0]    clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept, rd_go, wr_go, wr_do;
    logic                rd_fault, wr_fault;
    logic [IDX_W-1:0]    rd_idx, wr_idx, clr_idx;
    logic [DATA_W-1:0]   rd_word;

    function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] hi;
        hi = a >> HI_LSB;
        return (a[BO_W-1:0] != '0) || (hi != '0);
    endfunction

    assign accept   = (state == S_IDLE);
    assign rd_go    = accept && RReq;
    assign wr_go    = accept && WEn;
    assign rd_fault = addr_fault(RAddr);
    assign wr_fault = addr_fault(WAddr);
    assign wr_do    = wr_go && !wr_fault;
    assign rd_idx   = {ASID[PART_W-1:0], RAddr[HI_LSB-1:BO_W]};
    assign wr_idx   = {ASID[PART_W-1:0], WAddr[HI_LSB-1:BO_W]};
    assign clr_idx  = {clr_part, clr_cnt};

    assign RReady    = accept;
    assign WReady    = accept;
    assign Busy      = (state == S_CLEAR);
    assign ClrDone   = (state == S_DONE);
    assign dbg_state = state;

    // The clear engine owns the write port whenever it runs; no request is accepted then.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_do) begin
            for (int b = 0; b < BE_W; b++) begin
                if (WBe[b]) mem[wr_idx][b*8 +: 8] <= WData[b*8 +: 8];
            end
        end
    end

    // Write-first forwarding for a same-cycle read of the word being written.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_do && (wr_idx == rd_idx)) begin
            for (int b = 0; b < BE_W; b++) begin
                if (WBe[b]) rd_word[b*8 +: 8] = WData[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RValid <= 1'b0;
            RData  <= '0;
            RErr   <= 1'b0;
            WErr   <= 1'b0;
        end else begin
            RValid <= rd_go;
            RErr   <= rd_go && rd_fault;
            WErr   <= wr_go && wr_fault;
            if (rd_go) RData <= rd_fault ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            clr_part <= '0;
            clr_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            clr_part <= clr_part_nxt;
            clr_cnt  <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_part_nxt = clr_part;
        clr_cnt_nxt  = clr_cnt;
        case (state)
            S_IDLE: begin
                if (ClrReq) begin
                    state_nxt    = S_CLEAR;
                    clr_part_nxt = ClrAsid[PART_W-1:0];
                    clr_cnt_nxt  = '0;
                end
            end
            S_CLEAR: begin
                clr_cnt_nxt = clr_cnt + OFF_W'(1);
                if (clr_cnt == OFF_W'(PW - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Upper ASID bits only distinguish requesters, not partitions.
    logic unused_ok;
    assign unused_ok = &{1'b0, ASID[ASID_W-1:PART_W], ClrAsid[ASID_W-1:PART_W]};

endmodule

// File: tb/tb_dm_asid_bank.sv
// Bench for dm_asid_bank: vector table, write-first and byte-lane cases,
// partition clear with blocked requests, and reset in the middle of a clear.
module tb_dm_asid_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ASID;
    logic        RReq;
    logic [31:0] RAddr;
    logic        RReady, RValid, RErr;
    logic [31:0] RData;
    logic        WEn;
    logic [31:0] WAddr;
    logic [3:0]  WBe;
    logic [31:0] WData;
    logic        WReady, WErr;
    logic        ClrReq;
    logic [7:0]  ClrAsid;
    logic        Busy, ClrDone;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [7:0]  asid;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        err;
    } vec_t;
    vec_t vecs[$];

    dm_asid_bank dut (
        .clk(clk), .rst_n(rst_n), .ASID(ASID),
        .RReq(RReq), .RAddr(RAddr), .RReady(RReady), .RValid(RValid), .RData(RData), .RErr(RErr),
        .WEn(WEn), .WAddr(WAddr), .WBe(WBe), .WData(WData), .WReady(WReady), .WErr(WErr),
        .ClrReq(ClrReq), .ClrAsid(ClrAsid), .Busy(Busy), .ClrDone(ClrDone), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // scoreboard: every RValid pops one expected {err, data}
    always @(negedge clk) begin
        if (rst_n && RValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 64'(RValid), 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("read_resp", {31'd0, RErr, RData}, {31'd0, e});
            end
        end
    end

    // drivers
    task automatic do_write(input logic [7:0] asid, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, input logic exp_err);
        @(negedge clk);
        ASID = asid; WAddr = addr; WBe = be; WData = data; WEn = 1'b1;
        #1 chk("wready", 64'(WReady), 64'd1);
        @(posedge clk);
        #1 WEn = 1'b0;
        chk("werr", 64'(WErr), 64'(exp_err));
    endtask

    task automatic do_read(input logic [7:0] asid, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        ASID = asid; RAddr = addr; RReq = 1'b1;
        exp_q.push_back({exp_err, exp_err ? 32'h0 : exp_data});
        #1 chk("rready", 64'(RReady), 64'd1);
        @(posedge clk);
        #1 RReq = 1'b0;
    endtask

    task automatic do_rw(input logic [7:0] asid, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] exp_data);
        @(negedge clk);
        ASID = asid; WAddr = addr; WBe = be; WData = wdata; WEn = 1'b1;
        RAddr = addr; RReq = 1'b1;
        exp_q.push_back({1'b0, exp_data});
        @(posedge clk);
        #1 WEn = 1'b0; RReq = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rvalid"}, 64'(RValid), 64'd0);
        chk({tag, "_rdata"}, 64'(RData), 64'd0);
        chk({tag, "_rerr"}, 64'(RErr), 64'd0);
        chk({tag, "_werr"}, 64'(WErr), 64'd0);
        chk({tag, "_busy"}, 64'(Busy), 64'd0);
        chk({tag, "_clrdone"}, 64'(ClrDone), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        int busy_n, done_n;
        rst_n = 1'b0; ASID = '0; RReq = 1'b0; RAddr = '0; WEn = 1'b0; WAddr = '0;
        WBe = '0; WData = '0; ClrReq = 1'b0; ClrAsid = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        chk("por_rready", 64'(RReady), 64'd1);
        rst_n = 1'b1;

        // vector table: reads carry expected data, writes carry data to write
        vecs.push_back('{1'b1, 8'd1, 32'h10,  4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 8'd2, 32'h10,  4'hF, 32'h12345678, 1'b0});
        vecs.push_back('{1'b0, 8'd1, 32'h10,  4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 8'd2, 32'h10,  4'h0, 32'h12345678, 1'b0});
        vecs.push_back('{1'b0, 8'd5, 32'h10,  4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 8'd0, 32'h20,  4'hF, 32'h11223344, 1'b0});
        vecs.push_back('{1'b1, 8'd0, 32'h20,  4'h5, 32'hAABBCCDD, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 32'h20,  4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 8'd0, 32'h22,  4'hF, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 32'h20,  4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 32'h1000, 4'h0, 32'h0,       1'b1});
        vecs.push_back('{1'b0, 8'd0, 32'h21,  4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 8'd0, 32'h24,  4'hF, 32'h55AA55AA, 1'b0});
        vecs.push_back('{1'b1, 8'd0, 32'h24,  4'h0, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{1'b1, 8'd0, 32'h1024, 4'hF, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 32'h24,  4'h0, 32'h55AA55AA, 1'b0});
        vecs.push_back('{1'b1, 8'd3, 32'hFFC, 4'hF, 32'h0BADCAFE, 1'b0});
        vecs.push_back('{1'b0, 8'd3, 32'hFFC, 4'h0, 32'h0BADCAFE, 1'b0});

        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].asid, vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].err);
            else            do_read(vecs[i].asid, vecs[i].addr, vecs[i].data, vecs[i].err);
        end

        // same-cycle write and read: full word, then partial lanes over old data
        do_rw(8'd0, 32'h40, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D);
        do_write(8'd0, 32'h44, 4'hF, 32'h01020304, 1'b0);
        do_rw(8'd0, 32'h44, 4'hC, 32'hAABBCCDD, 32'hAABB0304);
        do_read(8'd0, 32'h44, 32'hAABB0304, 1'b0);

        // partition clear of ASID 3 with ASID 0 data alongside
        do_write(8'd0, 32'h30, 4'hF, 32'h000000A0, 1'b0);
        do_write(8'd0, 32'h50, 4'hF, 32'h77777777, 1'b0);
        do_write(8'd3, 32'h0,  4'hF, 32'h00000033, 1'b0);
        do_write(8'd3, 32'h30, 4'hF, 32'h00003030, 1'b0);
        @(negedge clk);
        ClrReq = 1'b1; ClrAsid = 8'd3;
        ASID = 8'd0; RAddr = 32'h20; RReq = 1'b1;
        exp_q.push_back({1'b0, 32'h11BB33DD});
        @(posedge clk);
        #1 ClrReq = 1'b0; RReq = 1'b0;
        busy_n = 0; done_n = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (Busy) busy_n++;
            if (ClrDone) done_n++;
            if (c >= 11 && c <= 15) begin
                chk("busy_rready", 64'(RReady), 64'd0);
                chk("busy_werr", 64'(WErr), 64'd0);
            end
            if (c == 10) begin
                ASID = 8'd0; RAddr = 32'h20; RReq = 1'b1;
                WAddr = 32'h50; WData = 32'hFFFFFFFF; WBe = 4'hF; WEn = 1'b1;
            end
            if (c == 15) begin RReq = 1'b0; WEn = 1'b0; end
        end
        chk("clear_busy_cycles", 64'(busy_n), 64'd1024);
        chk("clear_done_pulses", 64'(done_n), 64'd1);
        do_read(8'd3, 32'h0,   32'h0, 1'b0);
        do_read(8'd3, 32'h30,  32'h0, 1'b0);
        do_read(8'd3, 32'hFFC, 32'h0, 1'b0);
        do_read(8'd0, 32'h30,  32'h000000A0, 1'b0);
        do_read(8'd0, 32'h50,  32'h77777777, 1'b0);
        do_read(8'd1, 32'h10,  32'hDEADBEEF, 1'b0);

        // reset while the clear counter of partition 2 sits at 500
        do_write(8'd2, 32'h7CC, 4'hF, 32'h00000499, 1'b0);
        do_write(8'd2, 32'h7D0, 4'hF, 32'h00000500, 1'b0);
        do_write(8'd2, 32'h960, 4'hF, 32'h00000600, 1'b0);
        do_read(8'd2, 32'h960, 32'h00000600, 1'b0);
        @(negedge clk);
        ClrReq = 1'b1; ClrAsid = 8'd2;
        @(posedge clk);
        #1 ClrReq = 1'b0;
        repeat (500) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midclr");
        @(negedge clk);
        rst_n = 1'b1;
        do_read(8'd2, 32'h7CC, 32'h0, 1'b0);
        do_read(8'd2, 32'h7D0, 32'h00000500, 1'b0);
        do_read(8'd2, 32'h960, 32'h00000600, 1'b0);
        do_read(8'd2, 32'h10,  32'h0, 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
